// File: rtl/collision_scanner_if.sv
// rtl/collision_scanner_if.sv - frame/result bundle between frame generator, collision scanner and game control
interface collision_scanner_if #(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int LIVES = 3
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int NW = $clog2(ROWS * COLS + 1);
    localparam int LW = $clog2(LIVES + 1);

    logic                       restart;
    logic                       frame_valid;
    logic [ROWS-1:0][COLS-1:0]  GrnPixels;
    logic [ROWS-1:0][COLS-1:0]  RedPixels;
    logic                       busy;
    logic                       done;
    logic                       hit;
    logic [RW-1:0]              hit_row;
    logic [CW-1:0]              hit_col;
    logic [NW-1:0]              hit_count;
    logic [LW-1:0]              lives;
    logic                       gameover;
    logic                       overrun;
    logic                       grace_active;

    modport master (
        output restart, frame_valid, GrnPixels, RedPixels,
        input  busy, done, hit, hit_row, hit_col, hit_count,
               lives, gameover, overrun, grace_active
    );

    modport slave (
        input  restart, frame_valid, GrnPixels, RedPixels,
        output busy, done, hit, hit_row, hit_col, hit_count,
               lives, gameover, overrun, grace_active
    );
endinterface

// File: rtl/collision_scanner.sv
// rtl/collision_scanner.sv - row-serial green/red overlap scanner with lives counter; COLLISION_GRACE_EN adds a post-hit grace window
module collision_scanner #(
    parameter int ROWS         = 16,
    parameter int COLS         = 16,
    parameter int LIVES        = 3,
    parameter int GRACE_FRAMES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    collision_scanner_if.slave   bus
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int NW = $clog2(ROWS * COLS + 1);
    localparam int LW = $clog2(LIVES + 1);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    state_t                     state_q, state_d;
    logic [ROWS-1:0][COLS-1:0]  grn_snap, red_snap;
    logic [RW-1:0]              row_q;
    logic [NW-1:0]              acc_q;
    logic                       found_q;
    logic [RW-1:0]              first_row_q;
    logic [CW-1:0]              first_col_q;

    logic                       done_q, hit_q, gameover_q, overrun_q;
    logic [RW-1:0]              hit_row_q;
    logic [CW-1:0]              hit_col_q;
    logic [NW-1:0]              hit_count_q;
    logic [LW-1:0]              lives_q;

    logic [COLS-1:0]            ov;
    logic [NW-1:0]              ov_cnt;
    logic [CW-1:0]              ov_col;
    logic                       last_row;
    logic                       grace_hold;
    logic                       soft_rst;

    assign soft_rst = rst || bus.restart;
    assign last_row = (row_q == RW'(ROWS - 1));

    // Overlap of the current row: pixel count and lowest overlapping column
    always_comb begin
        ov     = grn_snap[row_q] & red_snap[row_q];
        ov_cnt = '0;
        ov_col = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            ov_cnt = ov_cnt + NW'(ov[c]);
            if (ov[c]) begin
                ov_col = CW'(c);
            end
        end
    end

    // Next-state logic: accept in IDLE, one row per cycle, one report cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.frame_valid) state_d = SCAN;
            SCAN:    if (last_row)        state_d = REPORT;
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; restart aborts a scan exactly like rst
    always_ff @(posedge clk) begin
        if (soft_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Snapshot, accumulation, result registers, lives and sticky flags
    always_ff @(posedge clk) begin
        if (soft_rst) begin
            row_q       <= '0;
            acc_q       <= '0;
            found_q     <= 1'b0;
            first_row_q <= '0;
            first_col_q <= '0;
            done_q      <= 1'b0;
            hit_q       <= 1'b0;
            hit_row_q   <= '0;
            hit_col_q   <= '0;
            hit_count_q <= '0;
            lives_q     <= LW'(LIVES);
            gameover_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != IDLE && bus.frame_valid) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (bus.frame_valid) begin
                        grn_snap    <= bus.GrnPixels;
                        red_snap    <= bus.RedPixels;
                        row_q       <= '0;
                        acc_q       <= '0;
                        found_q     <= 1'b0;
                        first_row_q <= '0;
                        first_col_q <= '0;
                    end
                end
                SCAN: begin
                    acc_q <= acc_q + ov_cnt;
                    if (!found_q && ov != '0) begin
                        found_q     <= 1'b1;
                        first_row_q <= row_q;
                        first_col_q <= ov_col;
                    end
                    row_q <= row_q + RW'(1);
                end
                REPORT: begin
                    done_q      <= 1'b1;
                    hit_q       <= found_q;
                    hit_row_q   <= first_row_q;
                    hit_col_q   <= first_col_q;
                    hit_count_q <= acc_q;
                    if (found_q && !grace_hold && lives_q != '0) begin
                        lives_q <= lives_q - LW'(1);
                        if (lives_q == LW'(1)) begin
                            gameover_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef COLLISION_GRACE_EN
    localparam int GW = (GRACE_FRAMES > 0) ? $clog2(GRACE_FRAMES + 1) : 1;
    logic [GW-1:0] grace_q;

    assign grace_hold = (grace_q != '0);

    // Grace window: loaded by a life loss, counted down by every later report
    always_ff @(posedge clk) begin
        if (soft_rst) begin
            grace_q <= '0;
        end else if (state_q == REPORT) begin
            if (grace_hold) begin
                grace_q <= grace_q - GW'(1);
            end else if (found_q && lives_q != '0) begin
                grace_q <= GW'(GRACE_FRAMES);
            end
        end
    end

    assign bus.grace_active = grace_hold;
`else
    assign grace_hold       = 1'b0;
    assign bus.grace_active = 1'b0;
`endif

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.hit       = hit_q;
    assign bus.hit_row   = hit_row_q;
    assign bus.hit_col   = hit_col_q;
    assign bus.hit_count = hit_count_q;
    assign bus.lives     = lives_q;
    assign bus.gameover  = gameover_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_collision_scanner.sv
// tb/tb_collision_scanner.sv - scoreboard bench for collision_scanner with a pixel-level reference model
module tb_collision_scanner;
    localparam int ROWS  = 16;
    localparam int COLS  = 16;
    localparam int LIVES = 3;
    localparam int GRACE = 2;

    typedef logic [ROWS-1:0][COLS-1:0] frame_t;
    typedef struct {
        int     hit;
        int     row;
        int     col;
        int     cnt;
        int     lives;
        int     gameover;
        int     grace;
        longint due;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    longint cyc = 0;
    int     checks = 0;
    int     errors = 0;
    int     m_lives = LIVES;
    int     m_grace = 0;
    exp_t   sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    collision_scanner_if #(.ROWS(ROWS), .COLS(COLS), .LIVES(LIVES)) bus();

    collision_scanner #(
        .ROWS(ROWS), .COLS(COLS), .LIVES(LIVES), .GRACE_FRAMES(GRACE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference: scan every pixel, first overlap in row-major order, then apply the lives rules
    function automatic void model_frame(input frame_t g, input frame_t r);
        exp_t e;
        int   cnt = 0;
        int   first = -1;
        for (int y = 0; y < ROWS; y++) begin
            for (int x = 0; x < COLS; x++) begin
                if (g[y][x] && r[y][x]) begin
                    cnt++;
                    if (first < 0) first = y * COLS + x;
                end
            end
        end
        e.hit = (cnt > 0) ? 1 : 0;
        e.cnt = cnt;
        e.row = (first < 0) ? 0 : first / COLS;
        e.col = (first < 0) ? 0 : first % COLS;
`ifdef COLLISION_GRACE_EN
        if (m_grace > 0) begin
            m_grace--;
        end else if (e.hit == 1 && m_lives > 0) begin
            m_lives--;
            m_grace = GRACE;
        end
`else
        if (e.hit == 1 && m_lives > 0) m_lives--;
`endif
        e.lives    = m_lives;
        e.gameover = (m_lives == 0) ? 1 : 0;
        e.grace    = (m_grace != 0) ? 1 : 0;
        e.due      = cyc + 18;
        sb.push_back(e);
    endfunction

    task automatic send(input frame_t g, input frame_t r);
        int n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) chk("send_timeout", 1, 0);
        bus.GrnPixels   = g;
        bus.RedPixels   = r;
        bus.frame_valid = 1'b1;
        model_frame(g, r);
        @(negedge clk);
        bus.frame_valid = 1'b0;
        bus.GrnPixels   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        bus.RedPixels   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic do_restart();
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
        m_lives = LIVES;
        m_grace = 0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_hit"}, bus.hit, 0);
        chk({tag, "_hit_row"}, bus.hit_row, 0);
        chk({tag, "_hit_col"}, bus.hit_col, 0);
        chk({tag, "_hit_count"}, bus.hit_count, 0);
        chk({tag, "_lives"}, bus.lives, LIVES);
        chk({tag, "_gameover"}, bus.gameover, 0);
        chk({tag, "_overrun"}, bus.overrun, 0);
        chk({tag, "_grace_active"}, bus.grace_active, 0);
    endtask

    task automatic random_frame(output frame_t g, output frame_t r);
        int d = $urandom_range(3, 40);
        for (int y = 0; y < ROWS; y++) begin
            for (int x = 0; x < COLS; x++) begin
                g[y][x] = ($urandom_range(0, d - 1) == 0);
                r[y][x] = ($urandom_range(0, d - 1) == 0);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t g, r;
        bus.restart     = 1'b0;
        bus.frame_valid = 1'b0;
        bus.GrnPixels   = '0;
        bus.RedPixels   = '0;

        // Monitor: pop and compare whenever the DUT strobes done
        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (!rst && bus.done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("latency", cyc, e.due);
                        chk("hit", bus.hit, e.hit);
                        chk("hit_row", bus.hit_row, e.row);
                        chk("hit_col", bus.hit_col, e.col);
                        chk("hit_count", bus.hit_count, e.cnt);
                        chk("lives", bus.lives, e.lives);
                        chk("gameover", bus.gameover, e.gameover);
                        chk("grace_active", bus.grace_active, e.grace);
                        chk("busy_in_done", bus.busy, 0);
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        g = '0; r = '0;
        g[4][12] = 1'b1; g[3][12] = 1'b1; r[5][12] = 1'b1; r[6][12] = 1'b1;
        send(g, r);
        g = '0; r = '0;
        g[4][13] = 1'b1; g[3][13] = 1'b1; r[4][13] = 1'b1; r[5][13] = 1'b1;
        send(g, r);
        g = '0; r = '0;
        g[5][12] = 1'b1; g[6][12] = 1'b1; r[5][12] = 1'b1; r[6][12] = 1'b1;
        send(g, r);
        g = '1; r = '1;
        send(g, r);
        drain();
        do_restart();
        chk("restart_lives", bus.lives, LIVES);
        chk("restart_gameover", bus.gameover, 0);

        g = '0; r = '0;
        g[4][13] = 1'b1; r[4][13] = 1'b1;
        for (int i = 0; i < 5; i++) send(g, r);
        drain();
        do_restart();
        chk("restart2_lives", bus.lives, LIVES);
        chk("restart2_gameover", bus.gameover, 0);
        chk("restart2_grace", bus.grace_active, 0);

        g = '0; r = '0;
        g[9][2] = 1'b1; r[9][2] = 1'b1; g[15][15] = 1'b1; r[15][15] = 1'b1;
        send(g, r);
        repeat (4) @(negedge clk);
        bus.GrnPixels   = '1;
        bus.RedPixels   = '1;
        bus.frame_valid = 1'b1;
        @(negedge clk);
        bus.frame_valid = 1'b0;
        chk("overrun_set", bus.overrun, 1);
        drain();
        chk("overrun_sticky", bus.overrun, 1);

        g = '1; r = '1;
        send(g, r);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        m_lives = LIVES;
        m_grace = 0;
        repeat (25) @(negedge clk);
        check_reset_values("midscan_rst");

        for (int i = 0; i < 40; i++) begin
            if (i % 8 == 7) begin
                drain();
                do_restart();
            end
            random_frame(g, r);
            send(g, r);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
